// File: rtl/tap_pkg.sv
// Shared constants and types for the byte tap reader and its ring memory.
package tap_pkg;

    localparam int DEFAULT_DEPTH = 99;
    localparam int BYTE_W        = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } tap_state_t;

endpackage

// File: rtl/byte_ring_mem.sv
// DEPTH x byte storage: one synchronous write port, one combinational read port, no reset.
module byte_ring_mem
    import tap_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [BYTE_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [BYTE_W-1:0] o_rdata
);

    logic [BYTE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/byte_tap_reader.sv
// Keeps the last DEPTH written bytes in a ring and returns the byte written k writes ago
// through a valid/ready request/response handshake.
module byte_tap_reader
    import tap_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_tap,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [BYTE_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [AW:0]       fill
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
    localparam logic [AW-1:0] LAST_P  = AW'(DEPTH - 1);

    tap_state_t        r_state, w_state_nxt;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW:0]       r_fill;
    logic [BYTE_W-1:0] r_rsp_data;
    logic              r_rsp_err;

    logic [AW:0]       w_ptr_ext, w_tap_ext, w_diff, w_idx;
    logic [AW-1:0]     w_raddr;
    logic [BYTE_W-1:0] w_rdata;
    logic              w_err, w_accept;

    byte_ring_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (wr_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Age -> slot: step back from the write pointer, folding negative results by DEPTH.
    assign w_ptr_ext = {1'b0, r_wr_ptr};
    assign w_tap_ext = {1'b0, req_tap};
    assign w_diff    = w_ptr_ext - ONE_W - w_tap_ext;
    assign w_idx     = (w_ptr_ext > w_tap_ext) ? w_diff : w_diff + DEPTH_W;
    assign w_err     = (w_tap_ext >= r_fill) || (w_tap_ext >= DEPTH_W);
    // Out-of-range taps never reach the array with an illegal address.
    assign w_raddr   = w_err ? '0 : w_idx[AW-1:0];

    assign req_ready = (r_state == IDLE) || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)
            w_state_nxt = RESP;
        else if (r_state == RESP && rsp_ready)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rsp_data <= w_err ? '0 : w_rdata;
                r_rsp_err  <= w_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
        end else if (wr_en) begin
            r_wr_ptr <= (r_wr_ptr == LAST_P) ? '0 : r_wr_ptr + AW'(1);
            if (r_fill != DEPTH_W) r_fill <= r_fill + ONE_W;
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign fill      = r_fill;

endmodule
